// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions for the NES-style bus slice.
// Holds the register addresses decoded by the sprite DMA engine and its state encoding.
package nes_bus_pkg;

    localparam logic [15:0] OAM_DMA_REG = 16'h4014;
    localparam logic [15:0] OAMDATA_REG = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// Sprite OAM DMA engine.
// Watches CPU writes for $4014. On a trigger it stalls the CPU, takes over the bus and copies
// 256 bytes from page $XX00-$XXFF into OAMDATA ($2004) as READ/WRITE cycle pairs.
//
// Build option: OAM_DMA_PARITY_ALIGN_EN adds the ALIGN state so the first READ always lands
// on an even-parity cycle (513 or 514 stall cycles). Without it the stall is always 513 cycles.
//
// Ports:
//   clk_ph1       CPU clock, all state on the rising edge
//   rst           asynchronous reset, active high
//   Addr_bus      CPU address output
//   Data_bus_out  CPU write data
//   R_nW          CPU read/not-write
//   Data_bus_in   read data returned by the memory map
//   cpu_rdy       low stalls the CPU
//   dma_active    bus mux select, 1 when the DMA owns the bus
//   dma_addr      DMA bus address
//   dma_data_out  DMA write data
//   dma_R_nW      DMA read/not-write
module oam_dma
    import nes_bus_pkg::*;
(
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] Addr_bus,
    input  logic [7:0]  Data_bus_out,
    input  logic        R_nW,
    input  logic [7:0]  Data_bus_in,
    output logic        cpu_rdy,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_data_out,
    output logic        dma_R_nW
);

    dma_state_e  state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_buf_q, data_buf_d;

    logic        cpu_rdy_q, cpu_rdy_d;
    logic        dma_active_q, dma_active_d;
    logic [15:0] dma_addr_q, dma_addr_d;
    logic [7:0]  dma_data_out_q, dma_data_out_d;
    logic        dma_r_nw_q, dma_r_nw_d;

`ifdef OAM_DMA_PARITY_ALIGN_EN
    logic        par_q;
`endif

    // Next-state logic. Only IDLE decodes the CPU bus, so DMA cycles cannot re-trigger.
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        data_buf_d = data_buf_q;
        case (state_q)
            IDLE: begin
                if (Addr_bus == OAM_DMA_REG && !R_nW) begin
                    page_d  = Data_bus_out;
                    idx_d   = 8'h00;
                    state_d = HALT;
                end
            end
            HALT: begin
`ifdef OAM_DMA_PARITY_ALIGN_EN
                // Even parity now means the next cycle is odd; burn one cycle to realign.
                state_d = par_q ? READ : ALIGN;
`else
                state_d = READ;
`endif
            end
`ifdef OAM_DMA_PARITY_ALIGN_EN
            ALIGN: state_d = READ;
`endif
            READ: begin
                data_buf_d = Data_bus_in;
                state_d    = WRITE;
            end
            WRITE: begin
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == 8'hFF) ? IDLE : READ;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered: decode them from the next state so they line up with it.
    always_comb begin
        cpu_rdy_d      = (state_d == IDLE);
        dma_active_d   = (state_d == READ) || (state_d == WRITE);
        dma_r_nw_d     = (state_d != WRITE);
        dma_addr_d     = 16'h0000;
        dma_data_out_d = 8'h00;
        if (state_d == READ) begin
            dma_addr_d = {page_d, idx_d};
        end else if (state_d == WRITE) begin
            dma_addr_d     = OAMDATA_REG;
            dma_data_out_d = data_buf_d;
        end
    end

    always_ff @(posedge clk_ph1 or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            page_q         <= 8'h00;
            idx_q          <= 8'h00;
            data_buf_q     <= 8'h00;
            cpu_rdy_q      <= 1'b1;
            dma_active_q   <= 1'b0;
            dma_addr_q     <= 16'h0000;
            dma_data_out_q <= 8'h00;
            dma_r_nw_q     <= 1'b1;
`ifdef OAM_DMA_PARITY_ALIGN_EN
            par_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            page_q         <= page_d;
            idx_q          <= idx_d;
            data_buf_q     <= data_buf_d;
            cpu_rdy_q      <= cpu_rdy_d;
            dma_active_q   <= dma_active_d;
            dma_addr_q     <= dma_addr_d;
            dma_data_out_q <= dma_data_out_d;
            dma_r_nw_q     <= dma_r_nw_d;
`ifdef OAM_DMA_PARITY_ALIGN_EN
            par_q          <= ~par_q;
`endif
        end
    end

    assign cpu_rdy      = cpu_rdy_q;
    assign dma_active   = dma_active_q;
    assign dma_addr     = dma_addr_q;
    assign dma_data_out = dma_data_out_q;
    assign dma_R_nW     = dma_r_nw_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: single-cycle IDLE decode vectors plus full transfers at both
// parities, a reset during a transfer, and a page $FF transfer.
module tb_oam_dma;

    logic        clk_ph1;
    logic        rst;
    logic [15:0] Addr_bus;
    logic [7:0]  Data_bus_out;
    logic        R_nW;
    logic [7:0]  Data_bus_in;
    logic        cpu_rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_out;
    logic        dma_R_nW;

    int checks = 0;
    int errors = 0;

    // Bench-side parity: cleared by reset, toggles every rising edge.
    logic tb_par;

    oam_dma dut (
        .clk_ph1      (clk_ph1),
        .rst          (rst),
        .Addr_bus     (Addr_bus),
        .Data_bus_out (Data_bus_out),
        .R_nW         (R_nW),
        .Data_bus_in  (Data_bus_in),
        .cpu_rdy      (cpu_rdy),
        .dma_active   (dma_active),
        .dma_addr     (dma_addr),
        .dma_data_out (dma_data_out),
        .dma_R_nW     (dma_R_nW)
    );

    initial clk_ph1 = 1'b0;
    always #5 clk_ph1 = ~clk_ph1;

    always @(posedge clk_ph1 or posedge rst) begin
        if (rst) tb_par <= 1'b0;
        else     tb_par <= ~tb_par;
    end

    // Memory model.
    assign Data_bus_in = dma_addr[7:0] ^ 8'hA5;

    typedef struct {
        logic [15:0] addr;
        logic        rnw;
        logic [7:0]  data;
        logic        exp_rdy;
        logic        exp_active;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        Addr_bus     = 16'h0000;
        R_nW         = 1'b1;
        Data_bus_out = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " cpu_rdy"}, {31'd0, cpu_rdy}, 32'd1);
        chk({tag, " dma_active"}, {31'd0, dma_active}, 32'd0);
        chk({tag, " dma_addr"}, {16'd0, dma_addr}, 32'h0);
        chk({tag, " dma_data_out"}, {24'd0, dma_data_out}, 32'h0);
        chk({tag, " dma_R_nW"}, {31'd0, dma_R_nW}, 32'd1);
    endtask

    // Trigger a transfer so that parity in the HALT cycle equals want_par, then follow it.
    // abort_at >= 0 asserts reset during the WRITE of that index and returns.
    task automatic run_dma(input logic [7:0] page, input logic want_par, input int abort_at);
        int stall;
        int rd;
        int wr;
        int first_rd;
        int exp_stall;
        int exp_first;
        bit done;
        logic [7:0] rd8;
        logic [7:0] wr8;
        exp_stall = 513;
        exp_first = 1;
`ifdef OAM_DMA_PARITY_ALIGN_EN
        if (!want_par) begin
            exp_stall = 514;
            exp_first = 2;
        end
`endif
        @(posedge clk_ph1); #1;
        while (tb_par == want_par) begin
            @(posedge clk_ph1); #1;
        end
        Addr_bus     = 16'h4014;
        R_nW         = 1'b0;
        Data_bus_out = page;
        @(posedge clk_ph1); #1;
        drive_idle();
        stall = 0; rd = 0; wr = 0; first_rd = -1; done = 0;
        for (int cyc = 0; cyc < 700 && !done; cyc++) begin
            @(negedge clk_ph1);
            if (cpu_rdy) begin
                done = 1;
            end else begin
                stall++;
                if (dma_active && dma_R_nW) begin
                    if (first_rd < 0) first_rd = cyc;
                    rd8 = rd[7:0];
                    chk("read addr", {16'd0, dma_addr}, {16'd0, page, rd8});
                    rd++;
                end else if (dma_active && !dma_R_nW) begin
                    wr8 = wr[7:0];
                    chk("write addr", {16'd0, dma_addr}, 32'h2004);
                    chk("write data", {24'd0, dma_data_out}, {24'd0, wr8 ^ 8'hA5});
                    if (wr == abort_at) begin
                        rst = 1'b1;
                        #1;
                        check_reset_outputs("abort");
                        #1;
                        rst = 1'b0;
                        return;
                    end
                    wr++;
                end
                @(posedge clk_ph1); #1;
            end
        end
        chk("transfer finished", {31'd0, done}, 32'd1);
        chk("stall cycles", stall, exp_stall);
        chk("first read cycle", first_rd, exp_first);
        chk("read count", rd, 256);
        chk("write count", wr, 256);
        chk("dma_active after done", {31'd0, dma_active}, 32'd0);
        chk("dma_R_nW after done", {31'd0, dma_R_nW}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{16'h4015, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[1] = '{16'h4014, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[2] = '{16'h2004, 1'b0, 8'h55, 1'b1, 1'b0};
        vecs[3] = '{16'h0014, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[4] = '{16'h4114, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[5] = '{16'h4014, 1'b0, 8'h07, 1'b0, 1'b0};

        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk_ph1);
        @(negedge clk_ph1);
        check_reset_outputs("reset");
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(posedge clk_ph1); #1;
            Addr_bus     = vecs[i].addr;
            R_nW         = vecs[i].rnw;
            Data_bus_out = vecs[i].data;
            @(posedge clk_ph1); #1;
            drive_idle();
            @(negedge clk_ph1);
            chk($sformatf("vec%0d cpu_rdy", i), {31'd0, cpu_rdy}, {31'd0, vecs[i].exp_rdy});
            chk($sformatf("vec%0d dma_active", i), {31'd0, dma_active},
                {31'd0, vecs[i].exp_active});
            chk($sformatf("vec%0d dma_R_nW", i), {31'd0, dma_R_nW}, 32'd1);
        end

        // Abandon the transfer started by the last vector.
        @(negedge clk_ph1);
        rst = 1'b1;
        #2;
        rst = 1'b0;

        run_dma(8'h02, 1'b1, -1);
        run_dma(8'h02, 1'b0, -1);
        run_dma(8'h01, 1'b1, 32'h40);
        @(negedge clk_ph1);
        chk("idle after abort cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
        chk("idle after abort dma_active", {31'd0, dma_active}, 32'd0);
        run_dma(8'h03, 1'b1, -1);
        run_dma(8'hFF, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite OAM DMA engine on the CPU bus, directly downstream of the CPU core's write port. It watches CPU bus writes for register $4014. On a trigger it stalls the CPU through its RDY input, takes over the address/data bus, and copies 256 bytes from CPU page $XX00–$XXFF into PPU register $2004 (OAMDATA). A read/write pair is issued for every byte.

## Interface
- Parameters: none (register addresses are package constants).
- clk_ph1  in  1  CPU clock. Single clock domain. All state updates on the rising edge.
- rst  in  1  Asynchronous reset, active-high.
- Addr_bus  in  16  CPU address output.
- Data_bus_out  in  8  CPU write data.
- R_nW  in  1  CPU read/not-write.
- Data_bus_in  in  8  Read data returned by the bus (memory map).
- cpu_rdy  out  1  Low stalls the CPU at its next read cycle.
- dma_active  out  1  Bus mux select. 1 means the DMA owns Addr/Data/R_nW.
- dma_addr  out  16  DMA bus address.
- dma_data_out  out  8  DMA write data.
- dma_R_nW  out  1  DMA read/not-write.

## Operation
- Parity flop `par` toggles on every clk_ph1. It resets to 0 (even).
- States:
  - IDLE: free-running watch of the CPU bus.
    - Trigger: Addr_bus==16'h4014 && R_nW==0 in a cycle.
    - On trigger: latch page<=Data_bus_out, idx<=8'h00, go to HALT.
  - HALT: 1 cycle. cpu_rdy=0, dma_active=0.
    - Next state is ALIGN if par==0 during HALT (next cycle odd); otherwise READ.
  - ALIGN: 1 cycle. cpu_rdy=0, dma_active=0. Next state READ.
  - READ: dma_addr={page,idx}, dma_R_nW=1, dma_active=1. Latch Data_bus_in into `buf` at the clock edge. Next state WRITE.
  - WRITE: dma_addr=16'h2004, dma_R_nW=0, dma_data_out=buf, dma_active=1.
    - idx<=idx+1 (8-bit wrap).
    - Next state is IDLE if idx==8'hFF; otherwise READ.
- Address arithmetic: idx is 8 bits and never carries into page. Page $FF copies $FF00–$FFFF only.
- cpu_rdy=0 in HALT/ALIGN/READ/WRITE. cpu_rdy=1 in IDLE.
- Triggers are ignored outside IDLE. DMA-issued bus cycles never re-trigger.
- A $4014 read (R_nW=1) never triggers.
- Reset mid-transfer: immediate return to IDLE. All outputs take reset values. page, idx and buf clear. No partial-resume state is kept.
- Reset values:
  - cpu_rdy=1, dma_active=0, dma_addr=16'h0000, dma_data_out=8'h00, dma_R_nW=1.
  - state=IDLE, par=0.

## Timing
- Trigger write in cycle T. HALT is in cycle T+1.
- First READ lands on an even-parity cycle:
  - If par(T+1)==1: READ at T+2. Total stall is 513 cycles (T+1..T+513).
  - Otherwise: ALIGN at T+2, READ at T+3. Total stall is 514 cycles.
- Each byte takes 2 cycles: READ, then WRITE. Read data is sampled at the end of READ and driven in the following WRITE.
- cpu_rdy returns to 1 in the cycle after the 256th WRITE. The CPU resumes on that cycle.
- All outputs are registered or decoded from registered state. No combinational path from Addr_bus to cpu_rdy.

## Configuration
- OAM_DMA_PARITY_ALIGN_EN defined: ALIGN state present. Stall is 513 or 514 cycles by parity, as above.
- Not defined: ALIGN state removed. HALT always goes to READ. Stall is always 513 cycles. `par` may be optimized away.

## Structure
- Shared package nes_bus_pkg holds:
  - OAM_DMA_REG=16'h4014
  - OAMDATA_REG=16'h2004
  - the DMA state enum (IDLE, HALT, ALIGN, READ, WRITE)
- No sub-module. A single FSM plus counter, parity flop and data latch is natural as one module.

## Test plan
- Memory model returns addr[7:0]^8'hA5. Even-parity trigger: write $02 to $4014 with par(T+1)==1.
  - Required: 513 cycles of cpu_rdy=0.
  - Reads at $0200..$02FF.
  - 256 writes to $2004 with data (i^$A5) in order.
- Same stimulus with par(T+1)==0 -> exactly 514 stall cycles. First READ is one cycle later; data sequence is identical.
- CPU read of $4014 (R_nW=1) -> no state change; cpu_rdy stays 1, dma_active stays 0.
- Assert rst during the WRITE of idx=$40.
  - Required: next sample shows reset values on all outputs.
  - A new trigger with page $03 restarts at $0300.
- Trigger with page $FF -> reads $FF00..$FFFF. No access to $0000; the final address is $FFFF.
- Build without OAM_DMA_PARITY_ALIGN_EN, triggers at both parities -> stall is 513 cycles both times.
